// File: rtl/pending_index_scheduler_pkg.sv
// Shared types and elaboration helpers for the pending index scheduler.
package pending_index_scheduler_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Upper bound on the request vector, sized for the popcount helper argument.
  localparam int MAX_VECTOR_LENGTH = 256;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int popcount(input logic [MAX_VECTOR_LENGTH-1:0] vector);
    int count;
    count = 0;
    for (int i = 0; i < MAX_VECTOR_LENGTH; i++) count += int'(vector[i]);
    return count;
  endfunction

endpackage

// File: rtl/find_last_one_index.sv
// Combinational priority encoder: reports the index of the highest set bit.
module find_last_one_index #(
  parameter int VECTOR_LENGTH    = 8,
  parameter int MAX_OUTPUT_WIDTH = 16
) (
  input  logic [VECTOR_LENGTH-1:0]    vector_in,
  output logic                        one_is_found_out,
  output logic [MAX_OUTPUT_WIDTH-1:0] index_out
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    one_is_found_out = 1'b0;
    index_out        = '0;
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      if (vector_in[i]) begin
        one_is_found_out = 1'b1;
        index_out        = MAX_OUTPUT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/pending_index_scheduler.sv
// Merges request pulses into a pending set and issues their indices highest-first
// through a one-entry registered valid/ready output stage.
module pending_index_scheduler
  import pending_index_scheduler_pkg::*;
#(
  parameter int VECTOR_LENGTH = 8,
  parameter int INDEX_WIDTH   = 16,
  parameter int COUNT_WIDTH   = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [VECTOR_LENGTH-1:0] set_vector_in,
  input  logic                     set_valid_in,
  input  logic                     clear_all_in,
  output logic [INDEX_WIDTH-1:0]   index_out,
  output logic                     index_valid_out,
  input  logic                     index_ready_in,
  output logic [VECTOR_LENGTH-1:0] pending_vector_out,
  output logic [COUNT_WIDTH-1:0]   pending_count_out,
  output logic                     duplicate_out
);

  if (VECTOR_LENGTH < 1 || VECTOR_LENGTH > MAX_VECTOR_LENGTH ||
      INDEX_WIDTH < clog2(VECTOR_LENGTH) ||
      COUNT_WIDTH < clog2(VECTOR_LENGTH + 1)) begin : g_param_check
    $error("pending_index_scheduler: width parameters too small for VECTOR_LENGTH");
  end

  state_t                   state_q;
  logic [VECTOR_LENGTH-1:0] pending_q;
  logic [VECTOR_LENGTH-1:0] pending_next;
  logic [VECTOR_LENGTH-1:0] retire_mask;
  logic [VECTOR_LENGTH-1:0] set_mask;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [INDEX_WIDTH-1:0]   enc_index;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     enc_found;
  logic                     accept;
  logic                     load;
  logic                     dup_hit;
  logic                     dup_q;

  // The encoder sees only registered pending bits; new sets wait one cycle.
  find_last_one_index #(
    .VECTOR_LENGTH   (VECTOR_LENGTH),
    .MAX_OUTPUT_WIDTH(INDEX_WIDTH)
  ) u_find_last_one_index (
    .vector_in       (pending_q),
    .one_is_found_out(enc_found),
    .index_out       (enc_index)
  );

  assign accept = (state_q == ST_HOLD) && index_ready_in;
  assign load   = enc_found && ((state_q == ST_EMPTY) || accept);

  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      retire_mask[i] = load && (enc_index == INDEX_WIDTH'(i));
    end
    set_mask = set_valid_in ? set_vector_in : '0;
    // A set of the bit retiring this cycle is not a duplicate; it re-arms the bit.
    dup_hit      = set_valid_in && |(set_vector_in & pending_q & ~retire_mask);
    pending_next = clear_all_in ? '0 : ((pending_q & ~retire_mask) | set_mask);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_EMPTY;
      index_q   <= '0;
      pending_q <= '0;
      count_q   <= '0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_next;
      count_q   <= COUNT_WIDTH'(popcount(MAX_VECTOR_LENGTH'(pending_next)));
      if (clear_all_in) begin
        state_q <= ST_EMPTY;
      end else if (load) begin
        state_q <= ST_HOLD;
        index_q <= enc_index;
      end else if (accept) begin
        state_q <= ST_EMPTY;
      end
      if (!clear_all_in && dup_hit) dup_q <= 1'b1;
    end
  end

  assign index_out          = index_q;
  assign index_valid_out    = (state_q == ST_HOLD);
  assign pending_vector_out = pending_q;
  assign pending_count_out  = count_q;
  assign duplicate_out      = dup_q;

endmodule

// File: tb/tb_pending_index_scheduler.sv
// Directed self-checking bench for pending_index_scheduler with hand-computed expectations.
module tb_pending_index_scheduler;

  logic        clk_in;
  logic        reset_n_in;
  logic [7:0]  set_vector_in;
  logic        set_valid_in;
  logic        clear_all_in;
  logic [15:0] index_out;
  logic        index_valid_out;
  logic        index_ready_in;
  logic [7:0]  pending_vector_out;
  logic [3:0]  pending_count_out;
  logic        duplicate_out;

  int compared;
  int mismatched;

  pending_index_scheduler #(
    .VECTOR_LENGTH(8),
    .INDEX_WIDTH  (16),
    .COUNT_WIDTH  (4)
  ) dut (
    .clk_in            (clk_in),
    .reset_n_in        (reset_n_in),
    .set_vector_in     (set_vector_in),
    .set_valid_in      (set_valid_in),
    .clear_all_in      (clear_all_in),
    .index_out         (index_out),
    .index_valid_out   (index_valid_out),
    .index_ready_in    (index_ready_in),
    .pending_vector_out(pending_vector_out),
    .pending_count_out (pending_count_out),
    .duplicate_out     (duplicate_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset_n_in     = 1'b0;
    set_vector_in  = '0;
    set_valid_in   = 1'b0;
    clear_all_in   = 1'b0;
    index_ready_in = 1'b0;
    tick();
    reset_n_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (index_out !== 16'd0) begin
      $display("FAIL reset_index: got %0d expected 0", index_out); mismatched++;
    end
    compared++;
    if (index_valid_out !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", index_valid_out); mismatched++;
    end
    compared++;
    if (pending_vector_out !== 8'h00) begin
      $display("FAIL reset_pending: got %h expected 00", pending_vector_out); mismatched++;
    end
    compared++;
    if (pending_count_out !== 4'd0) begin
      $display("FAIL reset_count: got %0d expected 0", pending_count_out); mismatched++;
    end
    compared++;
    if (duplicate_out !== 1'b0) begin
      $display("FAIL reset_dup: got %b expected 0", duplicate_out); mismatched++;
    end
  endtask

  task automatic test_drain_order();
    logic        exp_valid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_index [5] = '{16'd0, 16'd7, 16'd5, 16'd2, 16'd2};
    logic [3:0]  exp_count [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    do_reset();
    index_ready_in = 1'b1;
    set_vector_in  = 8'b1010_0100;
    set_valid_in   = 1'b1;
    tick();
    set_valid_in = 1'b0;
    // Rows cover cycles 1..5 after the set.
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (index_valid_out !== exp_valid[c]) begin
        $display("FAIL drain_valid cycle %0d: got %b expected %b", c + 1, index_valid_out, exp_valid[c]);
        mismatched++;
      end
      compared++;
      if (index_out !== exp_index[c]) begin
        $display("FAIL drain_index cycle %0d: got %0d expected %0d", c + 1, index_out, exp_index[c]);
        mismatched++;
      end
      compared++;
      if (pending_count_out !== exp_count[c]) begin
        $display("FAIL drain_count cycle %0d: got %0d expected %0d", c + 1, pending_count_out, exp_count[c]);
        mismatched++;
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    index_ready_in = 1'b0;
    set_vector_in  = 8'b0001_0010;
    set_valid_in   = 1'b1;
    tick();
    set_valid_in = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (index_valid_out !== 1'b1 || index_out !== 16'd4) begin
        $display("FAIL bp_hold cycle %0d: got valid=%b index=%0d expected valid=1 index=4", c, index_valid_out, index_out);
        mismatched++;
      end
      compared++;
      if (pending_vector_out !== 8'b0000_0010 || pending_count_out !== 4'd1) begin
        $display("FAIL bp_pending cycle %0d: got %b count %0d expected 00000010 count 1", c, pending_vector_out, pending_count_out);
        mismatched++;
      end
      tick();
    end
    index_ready_in = 1'b1;
    tick();
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd1) begin
      $display("FAIL bp_second: got valid=%b index=%0d expected valid=1 index=1", index_valid_out, index_out);
      mismatched++;
    end
    compared++;
    if (pending_vector_out !== 8'h00) begin
      $display("FAIL bp_pending_empty: got %h expected 00", pending_vector_out); mismatched++;
    end
    tick();
    compared++;
    if (index_valid_out !== 1'b0) begin
      $display("FAIL bp_done_valid: got %b expected 0", index_valid_out); mismatched++;
    end
  endtask

  task automatic test_same_cycle_reset();
    do_reset();
    index_ready_in = 1'b1;
    set_vector_in  = 8'b0001_0000;
    set_valid_in   = 1'b1;
    tick();
    // Index 4 loads in this cycle while the same bit is set again.
    tick();
    set_valid_in = 1'b0;
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd4 || pending_vector_out !== 8'b0001_0000) begin
      $display("FAIL reset_same_first: got valid=%b index=%0d pending=%b expected 1/4/00010000",
               index_valid_out, index_out, pending_vector_out);
      mismatched++;
    end
    tick();
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd4 || pending_vector_out !== 8'h00) begin
      $display("FAIL reset_same_second: got valid=%b index=%0d pending=%b expected 1/4/00000000",
               index_valid_out, index_out, pending_vector_out);
      mismatched++;
    end
    tick();
    compared++;
    if (index_valid_out !== 1'b0) begin
      $display("FAIL reset_same_drained: got %b expected 0", index_valid_out); mismatched++;
    end
    compared++;
    if (duplicate_out !== 1'b0) begin
      $display("FAIL reset_same_dup: got %b expected 0", duplicate_out); mismatched++;
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    index_ready_in = 1'b0;
    set_vector_in  = 8'b0100_0000;
    set_valid_in   = 1'b1;
    tick();
    set_vector_in = 8'b1000_0000;
    tick();
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd6 || pending_vector_out !== 8'b1000_0000 || duplicate_out !== 1'b0) begin
      $display("FAIL dup_setup: got valid=%b index=%0d pending=%b dup=%b expected 1/6/10000000/0",
               index_valid_out, index_out, pending_vector_out, duplicate_out);
      mismatched++;
    end
    set_vector_in = 8'b1000_0001;
    tick();
    set_valid_in = 1'b0;
    compared++;
    if (duplicate_out !== 1'b1) begin
      $display("FAIL dup_flag: got %b expected 1", duplicate_out); mismatched++;
    end
    compared++;
    if (pending_vector_out !== 8'b1000_0001 || pending_count_out !== 4'd2) begin
      $display("FAIL dup_merge: got %b count %0d expected 10000001 count 2", pending_vector_out, pending_count_out);
      mismatched++;
    end
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd6) begin
      $display("FAIL dup_hold: got valid=%b index=%0d expected 1/6", index_valid_out, index_out); mismatched++;
    end
    tick();
    compared++;
    if (duplicate_out !== 1'b1) begin
      $display("FAIL dup_sticky: got %b expected 1", duplicate_out); mismatched++;
    end
  endtask

  // Runs straight after test_duplicate, so the sticky flag is expected to survive the clear.
  task automatic test_clear_priority();
    clear_all_in   = 1'b1;
    set_valid_in   = 1'b1;
    set_vector_in  = 8'hFF;
    index_ready_in = 1'b1;
    tick();
    clear_all_in = 1'b0;
    set_valid_in = 1'b0;
    compared++;
    if (pending_vector_out !== 8'h00 || pending_count_out !== 4'd0) begin
      $display("FAIL clear_pending: got %h count %0d expected 00 count 0", pending_vector_out, pending_count_out);
      mismatched++;
    end
    compared++;
    if (index_valid_out !== 1'b0) begin
      $display("FAIL clear_valid: got %b expected 0", index_valid_out); mismatched++;
    end
    compared++;
    if (duplicate_out !== 1'b1) begin
      $display("FAIL clear_dup_kept: got %b expected 1", duplicate_out); mismatched++;
    end
    tick();
    compared++;
    if (index_valid_out !== 1'b0 || pending_vector_out !== 8'h00) begin
      $display("FAIL clear_idle: got valid=%b pending=%h expected 0/00", index_valid_out, pending_vector_out);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    index_ready_in = 1'b1;
    set_vector_in  = 8'hFF;
    set_valid_in   = 1'b1;
    tick();
    set_valid_in = 1'b0;
    tick();
    tick();
    compared++;
    if (index_valid_out !== 1'b1 || index_out !== 16'd6 || pending_count_out !== 4'd6) begin
      $display("FAIL mid_drain_progress: got valid=%b index=%0d count=%0d expected 1/6/6",
               index_valid_out, index_out, pending_count_out);
      mismatched++;
    end
    reset_n_in = 1'b0;
    tick();
    reset_n_in = 1'b1;
    compared++;
    if (index_valid_out !== 1'b0 || index_out !== 16'd0 || pending_vector_out !== 8'h00 ||
        pending_count_out !== 4'd0 || duplicate_out !== 1'b0) begin
      $display("FAIL mid_reset_values: got valid=%b index=%0d pending=%h count=%0d dup=%b expected 0/0/00/0/0",
               index_valid_out, index_out, pending_vector_out, pending_count_out, duplicate_out);
      mismatched++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (index_valid_out !== 1'b0 || pending_vector_out !== 8'h00) begin
        $display("FAIL mid_reset_quiet cycle %0d: got valid=%b pending=%h expected 0/00", c, index_valid_out, pending_vector_out);
        mismatched++;
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_drain_order();
    test_back_pressure();
    test_same_cycle_reset();
    test_duplicate();
    test_clear_priority();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pending_index_scheduler.md
# pending_index_scheduler

Holds a vector of pending one-hot requests and issues their indices one at a time, highest index first, over a valid/ready handshake. Incoming request pulses are merged into a pending register. A `find_last_one_index` instance picks the highest pending bit. The chosen index is loaded into a registered output stage, and its bit is retired from the pending set at that moment, so no index is issued twice. It sits directly upstream of index consumers such as writeback, replay or refill queues, and is the sequential front end that feeds the priority encoder.

## Interface
Parameters:
- `VECTOR_LENGTH`, 8, number of request bits.
- `INDEX_WIDTH`, 16, width of the issued index; passed to the encoder as `MAX_OUTPUT_WIDTH`; must be ≥ clog2(`VECTOR_LENGTH`).
- `COUNT_WIDTH`, 4, width of the pending count; must be ≥ clog2(`VECTOR_LENGTH`+1).

Ports:
- `clk_in` in 1: the single clock.
- `reset_n_in` in 1: synchronous, active-low reset.
- `set_vector_in` in `VECTOR_LENGTH`: request bits to add to the pending set.
- `set_valid_in` in 1: qualifies `set_vector_in`.
- `clear_all_in` in 1: flushes all pending requests and the output stage.
- `index_out` out `INDEX_WIDTH`: issued index.
- `index_valid_out` out 1: `index_out` is valid.
- `index_ready_in` in 1: consumer accepts the index.
- `pending_vector_out` out `VECTOR_LENGTH`: registered pending set, not including the index held in the output stage.
- `pending_count_out` out `COUNT_WIDTH`: popcount of `pending_vector_out`.
- `duplicate_out` out 1: sticky flag; a set hit a bit that was already pending.

## Operation
- Output stage FSM:
  - EMPTY (`index_valid_out`=0).
  - HOLD (`index_valid_out`=1).
- `load` = encoder `one_is_found_out` AND (state==EMPTY OR (`index_valid_out` AND `index_ready_in`)).
- EMPTY→HOLD on `load`.
- HOLD→HOLD on `load`, or when `index_ready_in`=0.
- HOLD→EMPTY when accepted with no `load`.
- The encoder input is the current pending register only. Incoming sets are never forwarded combinationally.
- On `load`:
  - `index_out` ← encoder index.
  - That bit is cleared from the next pending value.
- Pending next value, in priority order:
  1. `clear_all_in` → all zeros. The set is ignored, the FSM goes to EMPTY, and `duplicate_out` is unchanged.
  2. Otherwise next = (pending AND NOT retire_mask) OR (`set_valid_in` ? `set_vector_in` : 0).
- A set of the bit being retired in the same cycle wins: the bit stays pending and is issued again later.
- Duplicate detection: `set_valid_in` AND |(`set_vector_in` AND pending AND NOT retire_mask) sets `duplicate_out`.
  - Only `reset_n_in` clears `duplicate_out`.
  - Duplicates are merged; no count is lost or double-added.
- `pending_count_out` is registered and equals the popcount of the next pending value. A plain adder tree is used, no saturation needed.
- While HOLD with `index_ready_in`=0, `index_out` is held stable.
- Reset values:
  - `index_out`=0, `index_valid_out`=0 (EMPTY).
  - `pending_vector_out`=0, `pending_count_out`=0, `duplicate_out`=0.
- Reset mid-operation discards all pending and in-flight indices with no issue.

## Timing
- Set latency:
  - Set in cycle N → visible in `pending_vector_out`/`pending_count_out` at N+1.
  - → `index_valid_out` at N+2, if the output stage is EMPTY or accepted at N+1.
- Throughput is one index per cycle when `index_ready_in` is held high.
- Back-pressure never loses a request; new sets accumulate in pending.
- `clear_all_in` in cycle N → `index_valid_out`=0 and pending=0 at N+1, even if the consumer accepted in cycle N.
  - Acceptance in cycle N is still valid for the consumer.
  - Clear does not affect the handshake in cycle N itself.
- When pending is empty, the encoder reports not-found; no `load` occurs and `index_out` keeps its last value.

## Structure
- Shared package holds:
  - the FSM state encoding (EMPTY, HOLD);
  - a clog2 function for parameter checks;
  - a popcount function.
- One sub-module: `find_last_one_index`, instantiated with `VECTOR_LENGTH` and `MAX_OUTPUT_WIDTH`=`INDEX_WIDTH`. It is driven by the pending register, and its index is the load value.
- Elaboration check on the width parameters.

## Test plan
- Drain order: `VECTOR_LENGTH`=8; set 8'b1010_0100 at cycle 0 with ready high.
  - Expect `index_valid_out` from cycle 2, indices 7, 5, 2 on cycles 2–4, valid low at cycle 5.
  - Expect count sequence 3, 2, 1, 0 starting cycle 1.
- Back-pressure: pending 8'b0001_0010, ready low for 5 cycles.
  - Expect `index_out`=4 held stable and pending=8'b0000_0010.
  - On ready high: 4 then 1.
- Same-cycle re-set: while index 4 is loading, set 8'b0001_0000.
  - Expect 4 issued twice, `duplicate_out`=0.
- Duplicate: pending 8'b1000_0000 with output HOLD on index 6; set 8'b1000_0001.
  - Expect `duplicate_out`=1 sticky, pending=8'b1000_0001, count=2.
- Clear priority: `clear_all_in` with `set_valid_in` and vector 8'hFF.
  - Expect pending=0, count=0, valid=0 next cycle.
- Reset mid-drain: assert `reset_n_in`=0 for 1 cycle during a drain of 8'hFF.
  - Expect all outputs at reset values the next cycle and no further indices issued.
